// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART TX byte interface among NUM_REQ byte-stream requesters.
// A requester is granted by round-robin at packet start and holds the grant for the whole
// frame: SOF, source ID, payload (up to MAX_LEN bytes), XOR checksum over ID and payload.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   req_valid  per-requester byte valid                    [NUM_REQ-1:0]
//   req_data   per-requester byte, requester i at [8i+7:8i] [8*NUM_REQ-1:0]
//   req_last   per-requester final-payload-byte marker     [NUM_REQ-1:0]
//   req_ready  per-requester byte accept                   [NUM_REQ-1:0]
//   tx_byte    byte to the UART TX core                    [7:0]
//   tx_valid   tx_byte valid
//   tx_ready   UART TX core can accept a byte
//   grant_id   currently granted requester                 [2:0]
//   busy       high whenever a frame is in progress
//   len_err    sticky, a packet was truncated at MAX_LEN
//
// Optional feature, enabled by defining UART_TX_SCHED_STAT_EN:
//   pkt_cnt    [15:0] frames whose checksum byte was accepted (wrapping)
//   drop_cnt   [7:0]  truncated packets (saturating)
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SOF     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   len_err
`ifdef UART_TX_SCHED_STAT_EN
  ,
  output logic [15:0]            pkt_cnt,
  output logic [7:0]             drop_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StHdrSof,
    StHdrId,
    StPayload,
    StChksum
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_valid_q, tx_valid_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] cnt_q, cnt_d;
  logic       len_err_q, len_err_d;

  logic       slot_free;
  logic       chk_load;
  logic       trunc;

  // Requester buses padded to the 8-requester maximum so a 3-bit index is always in range.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic [7:0]  ready_pad;
  logic [7:0]  cur_data;

  logic [2:0]  pick_idx;
  logic        pick_found;
  logic [3:0]  pick_sum;
  logic [3:0]  grant_inc;

  assign slot_free = !tx_valid_q || tx_ready;
  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);
  assign cur_data  = data_pad[{grant_q, 3'b000} +: 8];
  assign grant_inc = {1'b0, grant_q} + 4'd1;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    pick_sum   = 4'd0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_sum = {1'b0, rr_ptr_q} + 4'(i);
      if (pick_sum >= 4'(NUM_REQ)) begin
        pick_sum = pick_sum - 4'(NUM_REQ);
      end
      if (!pick_found && valid_pad[pick_sum[2:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[2:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    chk_d      = chk_q;
    cnt_d      = cnt_q;
    len_err_d  = len_err_q;
    ready_pad  = 8'd0;
    chk_load   = 1'b0;
    trunc      = 1'b0;

    // The output slot empties when its byte is taken; a load below re-arms it.
    if (slot_free) begin
      tx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = StHdrSof;
        end
      end
      StHdrSof: begin
        if (slot_free) begin
          tx_byte_d  = SOF;
          tx_valid_d = 1'b1;
          state_d    = StHdrId;
        end
      end
      StHdrId: begin
        if (slot_free) begin
          tx_byte_d  = {5'b0, grant_q};
          tx_valid_d = 1'b1;
          chk_d      = {5'b0, grant_q};
          cnt_d      = 8'd0;
          state_d    = StPayload;
        end
      end
      StPayload: begin
        ready_pad[grant_q] = slot_free;
        if (slot_free && valid_pad[grant_q]) begin
          tx_byte_d  = cur_data;
          tx_valid_d = 1'b1;
          chk_d      = chk_q ^ cur_data;
          cnt_d      = 8'(cnt_q + 8'd1);
          if (last_pad[grant_q]) begin
            state_d = StChksum;
          end else if (cnt_q == 8'(MAX_LEN - 1)) begin
            state_d   = StChksum;
            len_err_d = 1'b1;
            trunc     = 1'b1;
          end
        end
      end
      StChksum: begin
        if (slot_free) begin
          tx_byte_d  = chk_q;
          tx_valid_d = 1'b1;
          rr_ptr_d   = (grant_inc >= 4'(NUM_REQ)) ? 3'd0 : grant_inc[2:0];
          chk_load   = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tx_byte_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      grant_q    <= 3'd0;
      rr_ptr_q   <= 3'd0;
      chk_q      <= 8'd0;
      cnt_q      <= 8'd0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      chk_q      <= chk_d;
      cnt_q      <= cnt_d;
      len_err_q  <= len_err_d;
    end
  end

`ifdef UART_TX_SCHED_STAT_EN
  // chk_pend marks that the byte in the output slot is a checksum; a frame counts once
  // that byte is actually taken by the UART core.
  logic        chk_pend_q, chk_pend_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  always_comb begin
    chk_pend_d = chk_pend_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (chk_pend_q && tx_valid_q && tx_ready) begin
      pkt_cnt_d  = 16'(pkt_cnt_q + 16'd1);
      chk_pend_d = 1'b0;
    end
    if (chk_load) begin
      chk_pend_d = 1'b1;
    end
    if (trunc && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = 8'(drop_cnt_q + 8'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_pend_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      chk_pend_q <= chk_pend_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

  assign req_ready = ready_pad[NUM_REQ-1:0];
  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != StIdle);
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [2:0]  grant_id;
  logic        busy, len_err;
`ifdef UART_TX_SCHED_STAT_EN
  logic [15:0] pkt_cnt;
  logic [7:0]  drop_cnt;
`endif

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(2),
    .MAX_LEN(4),
    .SOF    (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant_id (grant_id),
    .busy     (busy),
    .len_err  (len_err)
`ifdef UART_TX_SCHED_STAT_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  int         checks = 0;
  int         failures = 0;
  int         busy_cycles = 0;
  logic [7:0] exp_q[$];
  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_i = 0;
  logic       held_v = 1'b0;
  logic [7:0] held_b = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected frame: SOF, ID, payload bytes (first byte in bits [7:0]), hand-computed checksum.
  task automatic exp_frame(input logic [7:0] id, input int n, input logic [63:0] bytes,
                           input logic [7:0] cs);
    exp_q.push_back(8'hA5);
    exp_q.push_back(id);
    for (int i = 0; i < n; i++) exp_q.push_back(bytes[8*i +: 8]);
    exp_q.push_back(cs);
  endtask

  task automatic push_byte(input int id, input logic [7:0] b, input logic last);
    int n = 0;
    if (id == 0) begin v0 = 1'b1; d0 = b; l0 = last; end
    else         begin v1 = 1'b1; d1 = b; l1 = last; end
    forever begin
      @(negedge clk);
      if (req_ready[id]) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL req%0d_handshake_timeout: got no ready expected ready", id);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (id == 0) begin v0 = 1'b0; l0 = 1'b0; end
    else         begin v1 = 1'b0; l1 = 1'b0; end
  endtask

  task automatic send_pkt(input int id, input int n, input logic [63:0] bytes,
                          input logic mark_last);
    for (int i = 0; i < n; i++) push_byte(id, bytes[8*i +: 8], mark_last && (i == n - 1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 600 && !(exp_q.size() == 0 && !busy && !tx_valid)) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, {exp_q.size() == 0, busy, tx_valid}, 3'b100);
  endtask

  // Backpressure source: 1,0,0,1 repeating when enabled, otherwise always ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        tx_ready = bp_pat[bp_i];
        bp_i     = (bp_i + 1) % 4;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and checks the held byte under stall.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("tx_valid_hold", tx_valid, 1'b1);
          chk("tx_byte_hold", tx_byte, held_b);
          held_v = 1'b0;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: got %0h expected no byte", tx_byte);
          end else begin
            chk("tx_byte", tx_byte, exp_q.pop_front());
          end
        end else if (tx_valid) begin
          held_v = 1'b1;
          held_b = tx_byte;
        end
        if (busy) busy_cycles++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_grant", grant_id, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single packet from req0: A5 00 12 34 26.
    busy_cycles = 0;
    exp_frame(8'h00, 2, 64'h3412, 8'h26);
    send_pkt(0, 2, 64'h3412, 1'b1);
    wait_idle("single_drain");
    chk("single_busy_cycles", busy_cycles, 5);
    chk("single_len_err", len_err, 1'b0);

    // Same packet under backpressure.
    bp_en = 1'b1;
    exp_frame(8'h00, 2, 64'h3412, 8'h26);
    send_pkt(0, 2, 64'h3412, 1'b1);
    wait_idle("bp_drain");
    bp_en = 1'b0;
    @(negedge clk);

    // Truncation at MAX_LEN=4; the rest of the stream forms a second packet.
    exp_frame(8'h01, 4, 64'h44332211, 8'h45);
    exp_frame(8'h01, 2, 64'h6655, 8'h32);
    send_pkt(1, 6, 64'h665544332211, 1'b1);
    wait_idle("trunc_drain");
    chk("trunc_len_err", len_err, 1'b1);

    // Contention: req0 first, then req1, then req0's second packet.
    exp_frame(8'h00, 2, 64'h3412, 8'h26);
    exp_frame(8'h01, 1, 64'hFF, 8'hFE);
    exp_frame(8'h00, 1, 64'h56, 8'h56);
    fork
      begin
        send_pkt(0, 2, 64'h3412, 1'b1);
        send_pkt(0, 1, 64'h56, 1'b1);
      end
      send_pkt(1, 1, 64'hFF, 1'b1);
    join
    wait_idle("contention_drain");
`ifdef UART_TX_SCHED_STAT_EN
    chk("stat_pkt_cnt", pkt_cnt, 16'd7);
    chk("stat_drop_cnt", drop_cnt, 8'd1);
`endif

    // Reset after two payload bytes; byte 03 is pending but never sent.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    push_byte(0, 8'h01, 1'b0);
    push_byte(0, 8'h02, 1'b0);
    v0 = 1'b1;
    d0 = 8'h03;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_len_err", len_err, 1'b0);
    chk("midrst_queue", exp_q.size(), 0);
    v0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`ifdef UART_TX_SCHED_STAT_EN
    chk("midrst_pkt_cnt", pkt_cnt, 16'd0);
    chk("midrst_drop_cnt", drop_cnt, 8'd0);
`endif
    exp_frame(8'h00, 1, 64'h77, 8'h77);
    send_pkt(0, 1, 64'h77, 1'b1);
    wait_idle("postrst_drain");
    chk("postrst_grant", grant_id, 3'd0);
`ifdef UART_TX_SCHED_STAT_EN
    chk("postrst_pkt_cnt", pkt_cnt, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Packet scheduler that shares the single UART transmitter (which drives `tx_data`) among NUM_REQ byte-stream requesters, e.g. the inference result writer and the debug/status reporter.
- Grants one requester per packet using round-robin arbitration.
- Frames each packet as SOF, source ID, payload, then an XOR checksum.
- Pushes bytes to the UART TX core over a valid/ready handshake. Sits between datapath result logic and the UART TX instance in FPGA_top.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_LEN, 16, maximum payload bytes per packet (1..255).
- SOF, 8'hA5, start-of-frame byte.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  marks the final payload byte.
- req_ready  output  NUM_REQ  byte accepted when req_valid[i] && req_ready[i].
- tx_byte  output  8  byte to the UART TX core.
- tx_valid  output  1  tx_byte valid.
- tx_ready  input  1  UART TX core can accept a byte.
- grant_id  output  3  currently granted requester.
- busy  output  1  high in any state except IDLE.
- len_err  output  1  sticky; a packet was truncated at MAX_LEN.

Behaviour:
- Slot free (slot_free):
  - Definition: slot_free = !tx_valid || tx_ready.
  - Output register tx_byte/tx_valid loads only when slot_free.
  - When the slot is not free, tx_byte is held stable.
  - tx_valid drops to 0 when the byte is accepted and no new byte loads.
- Reset (rst=0, async): state=IDLE, tx_valid=0, tx_byte=0, grant_id=0, rr_ptr=0, chk=0, cnt=0, len_err=0, req_ready=0.
- FSM states: IDLE, HDR_SOF, HDR_ID, PAYLOAD, CHKSUM.
- IDLE:
  - When any req_valid is high, pick the first set bit searching from rr_ptr upward with wrap.
  - Register the pick in grant_id, go to HDR_SOF.
  - req_valid is only sampled here; nothing is consumed.
- HDR_SOF: on slot_free, load tx_byte=SOF, tx_valid=1, go to HDR_ID.
- HDR_ID: on slot_free, load tx_byte={5'b0,grant_id}, set chk=that byte, cnt=0, go to PAYLOAD.
- PAYLOAD:
  - req_ready[grant_id] = slot_free (combinational); all other req_ready bits = 0.
  - On a transfer: load tx_byte=req_data[g], chk^=byte, cnt++.
  - If req_last[g]=1 or cnt==MAX_LEN-1, go to CHKSUM.
  - If truncation occurs without req_last, set len_err.
- CHKSUM:
  - On slot_free, load tx_byte=chk, set rr_ptr=(grant_id+1) mod NUM_REQ, go to IDLE.
  - The grant is held for the whole packet; other requesters wait.
- Latency: the SOF byte appears on tx_valid 2 cycles after the req_valid edge that is sampled in IDLE.
- Throughput: with tx_ready held at 1, one byte per cycle. Packet of L payload bytes = L+3 bytes in L+3 consecutive cycles, plus 1 IDLE cycle between packets.
- Simultaneous requests: round-robin ensures no requester is served twice while another is waiting.
- Granted requester drops req_valid mid-packet: the FSM waits indefinitely in PAYLOAD; there is no timeout.
- Reset mid-packet: the frame is abandoned and tx_valid drops immediately. The UART core must tolerate the partial frame; the receiver resyncs on SOF.
- len_err is cleared only by reset.

Optional Feature:
- Macro: UART_TX_SCHED_STAT_EN.
- Defined:
  - Adds output pkt_cnt [15:0], incremented each time a CHKSUM byte is accepted (tx_valid && tx_ready in the cycle after CHKSUM loaded). Wraps 16'hFFFF to 0.
  - Adds output drop_cnt [7:0], incremented on each truncation; saturates at 8'hFF.
  - Both counters reset to 0.
- Not defined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Single packet: req0 sends 8'h12, 8'h34(last), tx_ready=1 → tx stream A5, 00, 12, 34, 26; busy high for 5 cycles; len_err=0.
- Backpressure: same packet with tx_ready toggling 1,0,0,1 → byte order unchanged, tx_byte stable while tx_ready=0, no req0 byte lost or duplicated.
- Contention: req0 and req1 both valid, req1 sending FF(last) → req0 packet first, then A5, 01, FF, FE. With both still pending, the next grant goes to req0 only after req1.
- Truncation: MAX_LEN=4, req1 streams 6 bytes with no last → 4 payload bytes, then checksum; len_err=1; remaining bytes start a new packet.
- Reset mid-PAYLOAD: rst=0 after 2 payload bytes → tx_valid=0, req_ready=0 immediately. After release, a new req0 packet starts with A5 and grant 0.
- With UART_TX_SCHED_STAT_EN: 3 packets plus 1 truncation → pkt_cnt=3, drop_cnt=1.
